match_controller: RTL and testbench

//  Parametrised penalty-shootout referee; successor to the fixed best-of-N score logic.

---
 rtl/match_controller.sv | 193 +++++++++++++++++++
 tb/tb_match_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
//   Penalty-shootout referee. Counts alternating kicks (the player always kicks
//   first), keeps per-side scores, ends the match as soon as the result can no
//   longer change (optional), and runs sudden death when regulation finishes
//   level. A draw is declared once SD_MAX sudden-death pairs are all level.
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   start         in   pulse: begin a new match (honoured in IDLE or DONE only)
//   abort         in   return to IDLE and clear everything; beats all inputs
//   round_done    in   pulse: current kick resolved (honoured in PLAY only)
//   is_scored     in   qualifies round_done: 1 = shooter scored
//   player_shoots out  1 = player shoots this kick, 0 = player keeps goal
//   kick_idx      out  kicks completed this match
//   score_player  out  player goals (saturating)
//   score_enemy   out  enemy goals (saturating)
//   sudden_death  out  regulation finished level; stays set in DONE
//   match_end     out  high while in DONE
//   match_result  out  1 = player won (valid with match_end)
//   match_draw    out  sudden death exhausted while level (valid with match_end)
// -----------------------------------------------------------------------------
module match_controller #(
   parameter  int ROUNDS    = 5,
   parameter  int SCORE_W   = 4,
   parameter  int SD_MAX    = 10,
   parameter  int EARLY_END = 1,
   localparam int IDX_W     = $clog2(2*(ROUNDS+SD_MAX)+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               round_done,
   input  logic               is_scored,
   output logic               player_shoots,
   output logic [IDX_W-1:0]   kick_idx,
   output logic [SCORE_W-1:0] score_player,
   output logic [SCORE_W-1:0] score_enemy,
   output logic               sudden_death,
   output logic               match_end,
   output logic               match_result,
   output logic               match_draw
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_CHECK,
      S_DONE
   } state_t;

   // Wide enough that score + remaining-kick sums never overflow.
   localparam int CW = IDX_W + SCORE_W + 2;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [IDX_W-1:0]   REG_KICKS = IDX_W'(2*ROUNDS);
   localparam logic [IDX_W-1:0]   SD_KICKS  = IDX_W'(2*(ROUNDS+SD_MAX));
   localparam logic [CW-1:0]      ROUNDS_W  = CW'(ROUNDS);

   state_t state;

   // -------------------------------------------------------------------------
   // Decision logic evaluated in CHECK, using the already-updated kick_idx
   // and scores from the PLAY cycle.
   // -------------------------------------------------------------------------
   logic [CW-1:0] sp_w, se_w, pk_w, ek_w;
   logic          early_win, early_loss, level;
   logic          chk_end, chk_result, chk_draw, chk_sd;

   always_comb begin
      sp_w = CW'(score_player);
      se_w = CW'(score_enemy);
      // Player kicks on odd indices, so the player has taken ceil(k/2).
      pk_w = (CW'(kick_idx) + CW'(1)) >> 1;
      ek_w = CW'(kick_idx) >> 1;
   end

   // Only meaningful in regulation where pk, ek <= ROUNDS, so the
   // subtractions cannot underflow there.
   assign early_win  = sp_w > (se_w + (ROUNDS_W - ek_w));
   assign early_loss = se_w > (sp_w + (ROUNDS_W - pk_w));
   assign level      = (score_player == score_enemy);

   always_comb begin
      chk_end    = 1'b0;
      chk_result = 1'b0;
      chk_draw   = 1'b0;
      chk_sd     = 1'b0;
      if (kick_idx < REG_KICKS) begin
         if (EARLY_END != 0) begin
            if (early_win) begin
               chk_end    = 1'b1;
               chk_result = 1'b1;
            end else if (early_loss) begin
               chk_end    = 1'b1;
            end
         end
      end else if (kick_idx == REG_KICKS) begin
         if (!level) begin
            chk_end    = 1'b1;
            chk_result = (score_player > score_enemy);
         end else begin
            chk_sd     = 1'b1;
         end
      end else if (!kick_idx[0]) begin
         // Sudden death is only judged after a complete pair.
         if (!level) begin
            chk_end    = 1'b1;
            chk_result = (score_player > score_enemy);
         end else if (kick_idx >= SD_KICKS) begin
            chk_end    = 1'b1;
            chk_draw   = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Main FSM with registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         player_shoots <= 1'b1;
         kick_idx      <= '0;
         score_player  <= '0;
         score_enemy   <= '0;
         sudden_death  <= 1'b0;
         match_end     <= 1'b0;
         match_result  <= 1'b0;
         match_draw    <= 1'b0;
      end else if (abort) begin
         state         <= S_IDLE;
         player_shoots <= 1'b1;
         kick_idx      <= '0;
         score_player  <= '0;
         score_enemy   <= '0;
         sudden_death  <= 1'b0;
         match_end     <= 1'b0;
         match_result  <= 1'b0;
         match_draw    <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               // DONE keeps every output frozen until a new start.
               if (start) begin
                  state         <= S_PLAY;
                  player_shoots <= 1'b1;
                  kick_idx      <= '0;
                  score_player  <= '0;
                  score_enemy   <= '0;
                  sudden_death  <= 1'b0;
                  match_end     <= 1'b0;
                  match_result  <= 1'b0;
                  match_draw    <= 1'b0;
               end
            end
            S_PLAY: begin
               if (round_done) begin
                  if (is_scored) begin
                     if (player_shoots) begin
                        if (score_player != SCORE_MAX)
                           score_player <= score_player + SCORE_W'(1);
                     end else begin
                        if (score_enemy != SCORE_MAX)
                           score_enemy <= score_enemy + SCORE_W'(1);
                     end
                  end
                  // Bounded by SD_KICKS: the match always ends there.
                  kick_idx <= kick_idx + IDX_W'(1);
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (chk_end) begin
                  state        <= S_DONE;
                  match_end    <= 1'b1;
                  match_result <= chk_result;
                  match_draw   <= chk_draw;
               end else begin
                  if (chk_sd)
                     sudden_death <= 1'b1;
                  player_shoots <= ~player_shoots;
                  state         <= S_PLAY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_match_controller.sv
// -----------------------------------------------------------------------------
// tb_match_controller
//   Three referees share one set of inputs:
//     dut 0: ROUNDS=5, SD_MAX=10, EARLY_END=1
//     dut 1: ROUNDS=5, SD_MAX=10, EARLY_END=0
//     dut 2: ROUNDS=5, SD_MAX=2,  EARLY_END=1
//   Each kick pushes the expected scoreboard entry (kick count, scores, and the
//   post-decision end/shooter/sudden-death state) before driving round_done;
//   the entry is popped and compared once the DUT has produced the result.
// -----------------------------------------------------------------------------
module tb_match_controller;

   logic clk = 1'b0;
   logic rst, start, abort, round_done, is_scored;

   logic       ps_o [3];
   logic [3:0] sp_o [3];
   logic [3:0] se_o [3];
   logic       sd_o [3];
   logic       me_o [3];
   logic       mr_o [3];
   logic       md_o [3];
   logic [4:0] ka, kb;
   logic [3:0] kc;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { int k; int sp; int se; bit done; bit ps; bit sd; } exp_t;
   typedef struct { logic [7:0] k; logic [7:0] sp; logic [7:0] se;
                    logic ps, sd, me, mr, md; } obs_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   match_controller #(.ROUNDS(5), .SCORE_W(4), .SD_MAX(10), .EARLY_END(1)) u_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .round_done(round_done), .is_scored(is_scored),
      .player_shoots(ps_o[0]), .kick_idx(ka), .score_player(sp_o[0]),
      .score_enemy(se_o[0]), .sudden_death(sd_o[0]), .match_end(me_o[0]),
      .match_result(mr_o[0]), .match_draw(md_o[0]));

   match_controller #(.ROUNDS(5), .SCORE_W(4), .SD_MAX(10), .EARLY_END(0)) u_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .round_done(round_done), .is_scored(is_scored),
      .player_shoots(ps_o[1]), .kick_idx(kb), .score_player(sp_o[1]),
      .score_enemy(se_o[1]), .sudden_death(sd_o[1]), .match_end(me_o[1]),
      .match_result(mr_o[1]), .match_draw(md_o[1]));

   match_controller #(.ROUNDS(5), .SCORE_W(4), .SD_MAX(2), .EARLY_END(1)) u_c (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .round_done(round_done), .is_scored(is_scored),
      .player_shoots(ps_o[2]), .kick_idx(kc), .score_player(sp_o[2]),
      .score_enemy(se_o[2]), .sudden_death(sd_o[2]), .match_end(me_o[2]),
      .match_result(mr_o[2]), .match_draw(md_o[2]));

   function automatic obs_t obs(input int d);
      obs_t o;
      o.k  = (d == 0) ? 8'(ka) : (d == 1) ? 8'(kb) : 8'(kc);
      o.sp = 8'(sp_o[d]);
      o.se = 8'(se_o[d]);
      o.ps = ps_o[d];
      o.sd = sd_o[d];
      o.me = me_o[d];
      o.mr = mr_o[d];
      o.md = md_o[d];
      return o;
   endfunction

   // Drive one round_done pulse; returns on the negedge after the sampling
   // edge, where the updated scores are visible.
   task automatic drive_kick(input bit sc);
      round_done = 1'b1;
      is_scored  = sc;
      @(negedge clk);
      round_done = 1'b0;
      is_scored  = 1'b0;
   endtask

   task automatic start_match();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o;
      for (int d = 0; d < 3; d++) begin
         o = obs(d);
         n_tests++;
         if (o.k !== 8'd0 || o.sp !== 8'd0 || o.se !== 8'd0 || o.ps !== 1'b1 ||
             o.sd !== 1'b0 || o.me !== 1'b0 || o.mr !== 1'b0 || o.md !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dut%0d: got k=%0d sp=%0d se=%0d ps=%b sd=%b end=%b res=%b draw=%b, want zeros with ps=1",
                     d, o.k, o.sp, o.se, o.ps, o.sd, o.me, o.mr, o.md);
         end
      end
   endtask

   // Player scores every kick, enemy misses every kick: decided after kick 6.
   task automatic test_early_end();
      exp_t e; obs_t o; int xsp = 0, xse = 0; bit sc;
      start_match();
      for (int i = 1; i <= 6; i++) begin
         sc = i[0];
         if (i[0]) xsp += int'(sc); else xse += int'(sc);
         sb.push_back('{k:i, sp:xsp, se:xse, done:(i == 6),
                        ps:((i == 6) ? i[0] : !i[0]), sd:1'b0});
         drive_kick(sc);
         e = sb.pop_front(); o = obs(0);
         n_tests++;
         if (o.k !== 8'(e.k) || o.sp !== 8'(e.sp) || o.se !== 8'(e.se)) begin
            n_fail++;
            $display("FAIL early_end kick%0d: got k=%0d %0d-%0d want k=%0d %0d-%0d",
                     i, o.k, o.sp, o.se, e.k, e.sp, e.se);
         end
         @(negedge clk); o = obs(0);
         n_tests++;
         if (o.me !== e.done || o.ps !== e.ps || o.sd !== e.sd) begin
            n_fail++;
            $display("FAIL early_end decide kick%0d: got end=%b ps=%b sd=%b want end=%b ps=%b sd=%b",
                     i, o.me, o.ps, o.sd, e.done, e.ps, e.sd);
         end
      end
      o = obs(0);
      n_tests++;
      if (o.mr !== 1'b1 || o.md !== 1'b0) begin
         n_fail++;
         $display("FAIL early_end result: got res=%b draw=%b want res=1 draw=0", o.mr, o.md);
      end
      // round_done while in DONE must not move anything.
      drive_kick(1'b1);
      @(negedge clk); o = obs(0);
      n_tests++;
      if (o.k !== 8'd6 || o.sp !== 8'd3 || o.se !== 8'd0 || o.me !== 1'b1) begin
         n_fail++;
         $display("FAIL done_frozen: got k=%0d %0d-%0d end=%b want k=6 3-0 end=1",
                  o.k, o.sp, o.se, o.me);
      end
   endtask

   // Same stimulus without early end: all ten regulation kicks are played.
   task automatic test_full_regulation();
      exp_t e; obs_t o; int xsp = 0, xse = 0; bit sc;
      start_match();
      for (int i = 1; i <= 10; i++) begin
         sc = i[0];
         if (i[0]) xsp += int'(sc); else xse += int'(sc);
         sb.push_back('{k:i, sp:xsp, se:xse, done:(i == 10),
                        ps:((i == 10) ? i[0] : !i[0]), sd:1'b0});
         drive_kick(sc);
         e = sb.pop_front(); o = obs(1);
         n_tests++;
         if (o.k !== 8'(e.k) || o.sp !== 8'(e.sp) || o.se !== 8'(e.se)) begin
            n_fail++;
            $display("FAIL full_reg kick%0d: got k=%0d %0d-%0d want k=%0d %0d-%0d",
                     i, o.k, o.sp, o.se, e.k, e.sp, e.se);
         end
         @(negedge clk); o = obs(1);
         n_tests++;
         if (o.me !== e.done || o.ps !== e.ps || o.sd !== e.sd) begin
            n_fail++;
            $display("FAIL full_reg decide kick%0d: got end=%b ps=%b sd=%b want end=%b ps=%b sd=%b",
                     i, o.me, o.ps, o.sd, e.done, e.ps, e.sd);
         end
      end
      o = obs(1);
      n_tests++;
      if (o.mr !== 1'b1 || o.md !== 1'b0) begin
         n_fail++;
         $display("FAIL full_reg result: got res=%b draw=%b want res=1 draw=0", o.mr, o.md);
      end
   endtask

   // 5-5 after regulation, kick 11 scores, kick 12 misses: 6-5 player wins.
   task automatic test_sudden_death();
      exp_t e; obs_t o; int xsp = 0, xse = 0; bit sc;
      start_match();
      for (int i = 1; i <= 12; i++) begin
         sc = (i <= 11);
         if (i[0]) xsp += int'(sc); else xse += int'(sc);
         sb.push_back('{k:i, sp:xsp, se:xse, done:(i == 12),
                        ps:((i == 12) ? i[0] : !i[0]), sd:(i >= 10)});
         drive_kick(sc);
         e = sb.pop_front(); o = obs(0);
         n_tests++;
         if (o.k !== 8'(e.k) || o.sp !== 8'(e.sp) || o.se !== 8'(e.se)) begin
            n_fail++;
            $display("FAIL sudden_death kick%0d: got k=%0d %0d-%0d want k=%0d %0d-%0d",
                     i, o.k, o.sp, o.se, e.k, e.sp, e.se);
         end
         @(negedge clk); o = obs(0);
         n_tests++;
         if (o.me !== e.done || o.ps !== e.ps || o.sd !== e.sd) begin
            n_fail++;
            $display("FAIL sudden_death decide kick%0d: got end=%b ps=%b sd=%b want end=%b ps=%b sd=%b",
                     i, o.me, o.ps, o.sd, e.done, e.ps, e.sd);
         end
      end
      o = obs(0);
      n_tests++;
      if (o.mr !== 1'b1 || o.md !== 1'b0) begin
         n_fail++;
         $display("FAIL sudden_death result: got res=%b draw=%b want res=1 draw=0", o.mr, o.md);
      end
   endtask

   // SD_MAX=2, every kick scores: declared draw at kick 14, 7-7.
   task automatic test_draw();
      exp_t e; obs_t o; int xsp = 0, xse = 0;
      start_match();
      for (int i = 1; i <= 14; i++) begin
         if (i[0]) xsp++; else xse++;
         sb.push_back('{k:i, sp:xsp, se:xse, done:(i == 14),
                        ps:((i == 14) ? i[0] : !i[0]), sd:(i >= 10)});
         drive_kick(1'b1);
         e = sb.pop_front(); o = obs(2);
         n_tests++;
         if (o.k !== 8'(e.k) || o.sp !== 8'(e.sp) || o.se !== 8'(e.se)) begin
            n_fail++;
            $display("FAIL draw kick%0d: got k=%0d %0d-%0d want k=%0d %0d-%0d",
                     i, o.k, o.sp, o.se, e.k, e.sp, e.se);
         end
         @(negedge clk); o = obs(2);
         n_tests++;
         if (o.me !== e.done || o.ps !== e.ps || o.sd !== e.sd) begin
            n_fail++;
            $display("FAIL draw decide kick%0d: got end=%b ps=%b sd=%b want end=%b ps=%b sd=%b",
                     i, o.me, o.ps, o.sd, e.done, e.ps, e.sd);
         end
      end
      o = obs(2);
      n_tests++;
      if (o.md !== 1'b1 || o.mr !== 1'b0) begin
         n_fail++;
         $display("FAIL draw result: got draw=%b res=%b want draw=1 res=0", o.md, o.mr);
      end
   endtask

   // Abort (synchronous) and reset (asynchronous) in the middle of a match.
   task automatic test_abort();
      obs_t o;
      bit pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int pass = 0; pass < 2; pass++) begin
         start_match();
         for (int i = 0; i < 4; i++) begin
            drive_kick(pat[i]);
            @(negedge clk);
         end
         o = obs(0);
         n_tests++;
         if (o.k !== 8'd4 || o.sp !== 8'd2 || o.se !== 8'd1 || o.me !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_setup pass%0d: got k=%0d %0d-%0d end=%b want k=4 2-1 end=0",
                     pass, o.k, o.sp, o.se, o.me);
         end
         if (pass == 0) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
         end else begin
            #2 rst = 1'b0;
            #1;
         end
         o = obs(0);
         n_tests++;
         if (o.k !== 8'd0 || o.sp !== 8'd0 || o.se !== 8'd0 || o.ps !== 1'b1 ||
             o.sd !== 1'b0 || o.me !== 1'b0 || o.mr !== 1'b0 || o.md !== 1'b0) begin
            n_fail++;
            $display("FAIL %s clear: got k=%0d %0d-%0d ps=%b sd=%b end=%b want zeros with ps=1",
                     (pass == 0) ? "abort" : "async_rst", o.k, o.sp, o.se, o.ps, o.sd, o.me);
         end
         if (pass == 1) begin
            @(negedge clk);
            rst = 1'b1;
         end
      end
   endtask

   // round_done held into CHECK, and start during PLAY, both ignored.
   task automatic test_ignored_inputs();
      obs_t o;
      start_match();
      round_done = 1'b1;
      is_scored  = 1'b1;
      @(negedge clk);        // PLAY -> CHECK, kick 1 counted
      @(negedge clk);        // still high in CHECK: must be ignored
      round_done = 1'b0;
      is_scored  = 1'b0;
      o = obs(0);
      n_tests++;
      if (o.k !== 8'd1 || o.sp !== 8'd1 || o.se !== 8'd0 || o.ps !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_in_check: got k=%0d %0d-%0d ps=%b want k=1 1-0 ps=0",
                  o.k, o.sp, o.se, o.ps);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      o = obs(0);
      n_tests++;
      if (o.k !== 8'd1 || o.sp !== 8'd1 || o.ps !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_play: got k=%0d sp=%0d ps=%b want k=1 sp=1 ps=0",
                  o.k, o.sp, o.ps);
      end
      drive_kick(1'b1);      // enemy kick: still in PLAY, so it counts
      o = obs(0);
      n_tests++;
      if (o.k !== 8'd2 || o.sp !== 8'd1 || o.se !== 8'd1) begin
         n_fail++;
         $display("FAIL play_after_start: got k=%0d %0d-%0d want k=2 1-1",
                  o.k, o.sp, o.se);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      round_done = 1'b0;
      is_scored  = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b1;
      @(negedge clk);
      test_early_end();
      test_full_regulation();
      test_sudden_death();
      test_draw();
      test_abort();
      test_ignored_inputs();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
